l2_mem_responder: RTL and testbench
===================================

Name: l2_mem_responder

Overview:
- Main-memory side responder for the L2 cache miss path.
- Accepts single-word write requests and block-refill read requests from L2 over a valid/ready request channel.
- Models a word-addressed backing store with fixed access latency.
- Returns a refill block as a critical-word-first burst with wrap-around, one word per cycle, no backpressure.

Parameters:
- DATA_WIDTH, 32, word width.
- BLOCK_SIZE, 4, words per block (power of 2, >=2).
- MEM_DEPTH, 1024, words in backing store (power of 2).
- READ_LATENCY, 4, cycles from request accept to first read beat (>=1).
- WRITE_LATENCY, 2, cycles from request accept to write commit (>=1).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- Mem_Req_Valid  in  1  request present.
- Mem_Req_Ready  out  1  responder can accept a request.
- Mem_Req_Write  in  1  1 = write, 0 = block read.
- Mem_Req_Address  in  32  byte address; word index = addr[log2(MEM_DEPTH)+1:2]; word-in-block = addr[log2(BLOCK_SIZE)+1:2].
- Mem_Write_Data  in  DATA_WIDTH  write data, sampled at accept.
- Mem_Resp_Valid  out  1  read beat valid.
- Mem_Resp_Data  out  DATA_WIDTH  read beat data.
- Mem_Resp_Word  out  log2(BLOCK_SIZE)  word-in-block index of current beat.
- Mem_Resp_Last  out  1  final beat of the burst.
- Mem_Write_Done  out  1  one-cycle pulse: write committed.
- Mem_Error  out  1  one-cycle pulse on the last beat or the done cycle of an out-of-range access.

Behaviour:
- Reset (rst low, async): FSM to IDLE; Mem_Req_Ready=1; all other outputs 0; counters 0.
  - Storage array is NOT reset; contents are preserved across reset.
  - A reset mid-burst or mid-write aborts the operation. A write not yet committed is dropped.
- States: IDLE, RD_WAIT, RD_BURST, WR_WAIT.
- IDLE:
  - Mem_Req_Ready=1.
  - Accept happens at a posedge with Valid&Ready. At accept, latch address, write flag and data; load the latency counter.
  - Go to RD_WAIT (read) or WR_WAIT (write). Ready=0 from the next cycle.
  - Requests offered while Ready=0 are ignored; L2 holds Valid until accepted.
- RD_WAIT:
  - Counter decrements each cycle.
  - Transition timing: accept edge T0; first beat visible in the cycle after edge T0+READ_LATENCY, so READ_LATENCY=1 gives a beat the cycle immediately after accept.
- RD_BURST:
  - Exactly BLOCK_SIZE consecutive cycles with Resp_Valid=1.
  - Beat n has Resp_Word = (start_word + n) mod BLOCK_SIZE, where start_word is the requested word-in-block (critical word first, wraps 3->0).
  - Resp_Data = mem[{block_base, Resp_Word}].
  - Resp_Last=1 only on beat BLOCK_SIZE-1.
  - After the last beat, return to IDLE; Ready=1 in the following cycle.
- WR_WAIT:
  - The word is written at edge T0+WRITE_LATENCY.
  - Mem_Write_Done=1 for the single following cycle, concurrent with the return to IDLE.
  - A read accepted afterwards returns the new value.
- Out of range: any of addr[31:log2(MEM_DEPTH)+2] nonzero.
  - Reads: full burst timing, all beats Data=0, Mem_Error=1 on the last beat.
  - Writes: storage unchanged, Mem_Error=1 with Write_Done.
- Address bits [1:0] are ignored.
- Resp_Data and Resp_Word are 0 whenever Resp_Valid=0.
- At most one outstanding request; no pipelining of requests.

Test Plan:
- Reset, then write 0xDEAD0000+i to words 0x40..0x43 (addr 0x100..0x10C) -> each Write_Done pulses exactly 2 cycles after accept; Ready low in between.
- Read addr 0x100 -> first beat 4 cycles after accept; beats Word=0,1,2,3, Data=0xDEAD0000..0xDEAD0003; Last only on Word=3; Ready back high the next cycle.
- Read addr 0x108 (critical word 2) -> beat order Word=2,3,0,1 with Data 0xDEAD0002, 0xDEAD0003, 0xDEAD0000, 0xDEAD0001.
- Hold Valid high with a second read during a burst -> not accepted until Ready returns; its first beat arrives 4 cycles after its own accept; no beat overlap.
- Write and read at addr 0x0001_0000 (out of range) -> Write_Done+Error pulse and memory unchanged; read gives 4 zero beats with Error on the last beat.
- Assert rst low during beat 2 of a burst -> outputs 0 asynchronously, Ready=1 after release; a subsequent read returns the preserved data.

Source files
------------

// File: rtl/l2_mem_responder_if.sv
// -----------------------------------------------------------------------------
// l2_mem_responder_if
//
// Purpose:
//    Bundles the L2 <-> main-memory miss-path signals: the valid/ready request
//    channel (single-word writes, block-refill reads) and the response side
//    (refill burst beats, write-done and error pulses).
//
// Modports:
//    master : L2 side. Drives the request, observes Ready and the responses.
//    slave  : memory responder. Observes the request, drives Ready and the
//             responses.
//
// Signals:
//    Mem_Req_Valid    L2 -> mem   request present
//    Mem_Req_Ready    mem -> L2   responder can accept a request
//    Mem_Req_Write    L2 -> mem   1 = single-word write, 0 = block read
//    Mem_Req_Address  L2 -> mem   byte address (bits [1:0] ignored)
//    Mem_Write_Data   L2 -> mem   write data, sampled at accept
//    Mem_Resp_Valid   mem -> L2   read beat valid
//    Mem_Resp_Data    mem -> L2   read beat data
//    Mem_Resp_Word    mem -> L2   word-in-block index of the current beat
//    Mem_Resp_Last    mem -> L2   final beat of the burst
//    Mem_Write_Done   mem -> L2   one-cycle pulse: write committed
//    Mem_Error        mem -> L2   one-cycle pulse: out-of-range access ended
// -----------------------------------------------------------------------------
interface l2_mem_responder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BLOCK_SIZE = 4
) ();

   localparam int WORD_W = $clog2(BLOCK_SIZE);

   logic                  Mem_Req_Valid;
   logic                  Mem_Req_Ready;
   logic                  Mem_Req_Write;
   logic [31:0]           Mem_Req_Address;
   logic [DATA_WIDTH-1:0] Mem_Write_Data;
   logic                  Mem_Resp_Valid;
   logic [DATA_WIDTH-1:0] Mem_Resp_Data;
   logic [WORD_W-1:0]     Mem_Resp_Word;
   logic                  Mem_Resp_Last;
   logic                  Mem_Write_Done;
   logic                  Mem_Error;

   modport master (
      output Mem_Req_Valid,
      output Mem_Req_Write,
      output Mem_Req_Address,
      output Mem_Write_Data,
      input  Mem_Req_Ready,
      input  Mem_Resp_Valid,
      input  Mem_Resp_Data,
      input  Mem_Resp_Word,
      input  Mem_Resp_Last,
      input  Mem_Write_Done,
      input  Mem_Error
   );

   modport slave (
      input  Mem_Req_Valid,
      input  Mem_Req_Write,
      input  Mem_Req_Address,
      input  Mem_Write_Data,
      output Mem_Req_Ready,
      output Mem_Resp_Valid,
      output Mem_Resp_Data,
      output Mem_Resp_Word,
      output Mem_Resp_Last,
      output Mem_Write_Done,
      output Mem_Error
   );

endinterface : l2_mem_responder_if

// File: rtl/l2_mem_responder.sv
// -----------------------------------------------------------------------------
// l2_mem_responder
//
// Purpose:
//    Main-memory side responder for the L2 miss path. Holds a word-addressed
//    backing store, accepts one request at a time, commits single-word writes
//    after WRITE_LATENCY cycles and returns refill blocks as a
//    critical-word-first, wrap-around burst of BLOCK_SIZE beats starting
//    READ_LATENCY cycles after accept. Accesses with any address bit above the
//    backing store set are out of range: reads return zero beats, writes are
//    dropped, and Mem_Error pulses at the end of the operation.
//
// Ports:
//    clk     in   clock, all state changes on posedge
//    rst     in   asynchronous active-low reset (storage is not cleared)
//    mem_if  slave modport of l2_mem_responder_if (request + response bus)
//
// Parameter constraints:
//    BLOCK_SIZE power of 2 and >= 2; MEM_DEPTH power of 2 and > BLOCK_SIZE,
//    with log2(MEM_DEPTH)+2 < 32; READ_LATENCY >= 1; WRITE_LATENCY >= 1.
// -----------------------------------------------------------------------------
module l2_mem_responder #(
   parameter int DATA_WIDTH    = 32,
   parameter int BLOCK_SIZE    = 4,
   parameter int MEM_DEPTH     = 1024,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 2
) (
   input logic               clk,
   input logic               rst,
   l2_mem_responder_if.slave mem_if
);

   localparam int AW      = $clog2(MEM_DEPTH);   // word-index width
   localparam int WW      = $clog2(BLOCK_SIZE);  // word-in-block width
   localparam int BW      = AW - WW;             // block-index width
   localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   // The counter is loaded with latency-1, so it only has to hold LAT_MAX-1.
   localparam int LW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   localparam logic [LW-1:0] RD_LOAD   = LW'(READ_LATENCY - 1);
   localparam logic [LW-1:0] WR_LOAD   = LW'(WRITE_LATENCY - 1);
   localparam logic [WW-1:0] LAST_BEAT = WW'(BLOCK_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RD_BURST = 2'd2,
      WR_WAIT  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t                state_q,  state_d;
   logic [LW-1:0]         lat_q,    lat_d;     // latency countdown
   logic [WW-1:0]         beat_q,   beat_d;    // beat number within burst
   logic [BW-1:0]         blk_q,    blk_d;     // block index of the request
   logic [WW-1:0]         start_q,  start_d;   // requested (critical) word
   logic                  oor_q,    oor_d;     // request was out of range
   logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;   // write data captured at accept
   logic                  done_q,   done_d;    // write-done pulse

   // Backing store and its registered read port
   logic [DATA_WIDTH-1:0] mem_array [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   logic          accept;
   logic          lat_zero;
   logic          last_beat;
   logic          mem_we;
   logic [WW-1:0] rd_word;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] wr_addr;

   // Byte-lane bits never select anything in a word-addressed store.
   logic unused_addr_bits;
   assign unused_addr_bits = ^mem_if.Mem_Req_Address[1:0];

   assign accept    = (state_q == IDLE) && mem_if.Mem_Req_Valid;
   assign lat_zero  = (lat_q == '0);
   assign last_beat = (beat_q == LAST_BEAT);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (mem_if.Mem_Req_Valid) begin
               state_d = mem_if.Mem_Req_Write ? WR_WAIT : RD_WAIT;
            end
         end
         // Counter reaches zero on the edge before the first beat, so the
         // first beat appears after edge accept+READ_LATENCY.
         RD_WAIT: begin
            if (lat_zero) begin
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            if (last_beat) begin
               state_d = IDLE;
            end
         end
         // The commit edge is also the edge that returns to IDLE, so the
         // done pulse and Ready=1 share the following cycle.
         WR_WAIT: begin
            if (lat_zero) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (combinational from state so reset clears them at once)
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_if.Mem_Req_Ready  = 1'b0;
      mem_if.Mem_Resp_Valid = 1'b0;
      mem_if.Mem_Resp_Data  = '0;
      mem_if.Mem_Resp_Word  = '0;
      mem_if.Mem_Resp_Last  = 1'b0;
      mem_if.Mem_Write_Done = done_q;
      mem_if.Mem_Error      = done_q && oor_q;
      unique case (state_q)
         IDLE: begin
            mem_if.Mem_Req_Ready = 1'b1;
         end
         RD_BURST: begin
            mem_if.Mem_Resp_Valid = 1'b1;
            mem_if.Mem_Resp_Word  = start_q + beat_q;
            mem_if.Mem_Resp_Last  = last_beat;
            // Out-of-range bursts keep the timing but return zero data.
            mem_if.Mem_Resp_Data  = oor_q ? '0 : rd_data_q;
            mem_if.Mem_Error      = last_beat && oor_q;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath next-state: request capture, latency countdown, beat counter
   // ---------------------------------------------------------------------------
   always_comb begin
      lat_d   = lat_q;
      beat_d  = beat_q;
      blk_d   = blk_q;
      start_d = start_q;
      oor_d   = oor_q;
      wdata_d = wdata_q;
      done_d  = (state_q == WR_WAIT) && lat_zero;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               blk_d   = mem_if.Mem_Req_Address[AW+1:WW+2];
               start_d = mem_if.Mem_Req_Address[WW+1:2];
               oor_d   = |mem_if.Mem_Req_Address[31:AW+2];
               wdata_d = mem_if.Mem_Write_Data;
               lat_d   = mem_if.Mem_Req_Write ? WR_LOAD : RD_LOAD;
               beat_d  = '0;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (!lat_zero) begin
               lat_d = lat_q - LW'(1);
            end
         end
         // Wraps to zero after the last beat because BLOCK_SIZE is a power of 2.
         RD_BURST: begin
            beat_d = beat_q + WW'(1);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_q   <= '0;
         beat_q  <= '0;
         blk_q   <= '0;
         start_q <= '0;
         oor_q   <= 1'b0;
         wdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         lat_q   <= lat_d;
         beat_q  <= beat_d;
         blk_q   <= blk_d;
         start_q <= start_d;
         oor_q   <= oor_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Backing store
   //
   // The read port is registered, so the address is presented one cycle ahead
   // of the beat that shows the data: during the last RD_WAIT cycle it points
   // at the critical word, and during beat n it points at word n+1. Wrap-around
   // within the block falls out of the WW-bit addition.
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_word = start_q;
      if (state_q == RD_BURST) begin
         rd_word = start_q + beat_q + WW'(1);
      end
   end

   assign rd_addr = {blk_q, rd_word};
   assign wr_addr = {blk_q, start_q};

   // Write commits on the edge that leaves WR_WAIT; a reset before then drops
   // it because mem_we is derived from the (reset) state register.
   assign mem_we  = (state_q == WR_WAIT) && lat_zero && !oor_q;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_array[wr_addr] <= wdata_q;
      end
      rd_data_q <= mem_array[rd_addr];
   end

endmodule : l2_mem_responder

// File: tb/tb_l2_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_l2_mem_responder
//
// Drives directed and random requests into l2_mem_responder. At each accept
// the expected responses (write-done pulse or BLOCK_SIZE burst beats, each
// with the cycle it must appear in) are computed from a word-array model and
// pushed into a queue; an independent monitor compares every response the
// DUT presents against the head of that queue.
// -----------------------------------------------------------------------------
module tb_l2_mem_responder;

   localparam int DW    = 32;
   localparam int BS    = 4;
   localparam int DEPTH = 1024;
   localparam int RL    = 4;
   localparam int WL    = 2;

   typedef struct {
      bit          is_beat;
      int          cyc;
      logic [31:0] data;
      int          word;
      bit          last;
      bit          err;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   bit   mon_en = 0;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] model_mem [int];

   l2_mem_responder_if #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS)) mif ();

   l2_mem_responder #(
      .DATA_WIDTH    (DW),
      .BLOCK_SIZE    (BS),
      .MEM_DEPTH     (DEPTH),
      .READ_LATENCY  (RL),
      .WRITE_LATENCY (WL)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .mem_if (mif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // cyc = number of posedges so far; sampled on negedges.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: expectations for one accepted request
   // ---------------------------------------------------------------------------
   task automatic push_exp(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int t0, input int nbeats);
      bit oor;
      int idx, start, base, w;
      exp_t e;
      oor   = (addr >= 32'(4 * DEPTH));
      idx   = int'((addr / 4) % DEPTH);
      start = idx % BS;
      base  = idx - start;
      if (wr) begin
         if (!oor) model_mem[idx] = wd;
         e = '{is_beat: 1'b0, cyc: t0 + WL, data: 32'd0, word: 0, last: 1'b0, err: oor};
         exp_q.push_back(e);
      end else begin
         for (int n = 0; n < nbeats; n++) begin
            w = (start + n) % BS;
            e = '{is_beat: 1'b1, cyc: t0 + RL + n,
                  data: oor ? 32'd0 : model_mem[base + w],
                  word: w, last: (n == BS - 1), err: oor && (n == BS - 1)};
            exp_q.push_back(e);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (mon_en) begin
         if (mif.Mem_Resp_Valid || mif.Mem_Write_Done) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_response: actual valid=%0b done=%0b required=none (cycle %0d)",
                        mif.Mem_Resp_Valid, mif.Mem_Write_Done, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("resp_kind_is_beat", 64'(mif.Mem_Resp_Valid), 64'(mon_e.is_beat));
               chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
               if (mon_e.is_beat) begin
                  chk("beat_data", 64'(mif.Mem_Resp_Data), 64'(mon_e.data));
                  chk("beat_word", 64'(mif.Mem_Resp_Word), 64'(mon_e.word));
                  chk("beat_last", 64'(mif.Mem_Resp_Last), 64'(mon_e.last));
                  chk("beat_error", 64'(mif.Mem_Error), 64'(mon_e.err));
               end else begin
                  chk("done_error", 64'(mif.Mem_Error), 64'(mon_e.err));
               end
            end
         end else begin
            chk("idle_outputs_zero",
                64'({mif.Mem_Resp_Data, mif.Mem_Resp_Word, mif.Mem_Resp_Last, mif.Mem_Error}), 64'd0);
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               checks++;
               $display("FAIL missed_response: actual=none required=%s at cycle %0d (now %0d)",
                        exp_q[0].is_beat ? "beat" : "done", exp_q[0].cyc, cyc);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------------
   task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int nbeats, output int t0);
      int waited;
      waited = 0;
      @(negedge clk);
      mif.Mem_Req_Valid   = 1'b1;
      mif.Mem_Req_Write   = wr;
      mif.Mem_Req_Address = addr;
      mif.Mem_Write_Data  = wd;
      while (!mif.Mem_Req_Ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!mif.Mem_Req_Ready) begin
         checks++;
         $display("FAIL accept_timeout: actual ready=0 required ready=1 within 200 cycles");
         mif.Mem_Req_Valid = 1'b0;
         t0 = -1;
         return;
      end
      t0 = cyc + 1;
      push_exp(wr, addr, wd, t0, nbeats);
      @(posedge clk);
      #1;
      mif.Mem_Req_Valid   = 1'b0;
      mif.Mem_Req_Write   = 1'($urandom);
      mif.Mem_Req_Address = $urandom;
      mif.Mem_Write_Data  = $urandom;
      @(negedge clk);
      chk("ready_low_after_accept", 64'(mif.Mem_Req_Ready), 64'd0);
      $display("txn %s addr=%08h wdata=%08h accepted at edge %0d", wr ? "WR" : "RD", addr, wd, t0);
   endtask

   task automatic wait_idle();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain_timeout: actual pending=%0d required pending=0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      chk("ready_high_after_op", 64'(mif.Mem_Req_Ready), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, ta, tb, waited;
      logic [31:0] a;
      rst                 = 1'b0;
      mif.Mem_Req_Valid   = 1'b0;
      mif.Mem_Req_Write   = 1'b0;
      mif.Mem_Req_Address = '0;
      mif.Mem_Write_Data  = '0;
      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(mif.Mem_Req_Ready), 64'd1);
      chk("reset_outputs_zero",
          64'({mif.Mem_Resp_Valid, mif.Mem_Resp_Data, mif.Mem_Resp_Word,
               mif.Mem_Resp_Last, mif.Mem_Write_Done, mif.Mem_Error}), 64'd0);
      rst    = 1'b1;
      mon_en = 1'b1;

      // Directed writes to words 0x40..0x43
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 32'h100 + 32'(4 * i), 32'hDEAD_0000 + 32'(i), 0, t);
         wait_idle();
      end
      // Aligned and critical-word-first reads
      issue(1'b0, 32'h100, 32'h0, BS, t);
      wait_idle();
      issue(1'b0, 32'h108, 32'h0, BS, t);
      wait_idle();

      // Second read offered during a burst waits for Ready
      issue(1'b0, 32'h104, 32'h0, BS, ta);
      issue(1'b0, 32'h10C, 32'h0, BS, tb);
      chk("held_request_accept_edge", 64'(tb), 64'(ta + RL + BS + 1));
      wait_idle();

      // Out-of-range write must not touch word 0; out-of-range read is zeros
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 32'(4 * i), 32'h1234_5670 + 32'(i), 0, t);
      end
      wait_idle();
      issue(1'b1, 32'h0001_0000, 32'hBAD0_BAD0, 0, t);
      wait_idle();
      issue(1'b0, 32'h0001_0000, 32'h0, BS, t);
      wait_idle();
      issue(1'b0, 32'h0000_0000, 32'h0, BS, t);
      wait_idle();

      // Reset during beat 2 of a burst: only beats 0 and 1 are expected
      issue(1'b0, 32'h100, 32'h0, 2, t);
      waited = 0;
      while (cyc < t + RL + 1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_valid", 64'(mif.Mem_Resp_Valid), 64'd0);
      chk("async_reset_data", 64'(mif.Mem_Resp_Data), 64'd0);
      chk("async_reset_ready", 64'(mif.Mem_Req_Ready), 64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_reset_release", 64'(mif.Mem_Req_Ready), 64'd1);
      issue(1'b0, 32'h104, 32'h0, BS, t);
      wait_idle();

      // Fill words 0x44..0x5F, then random mixed traffic over 0x40..0x5F
      for (int w = 16'h44; w < 16'h60; w++) begin
         issue(1'b1, 32'(4 * w), $urandom, 0, t);
      end
      wait_idle();
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
         else a = 32'(4 * $urandom_range(16'h40, 16'h5F)) | 32'($urandom_range(0, 3));
         issue(1'($urandom_range(0, 1)), a, $urandom, BS, t);
         if ($urandom_range(0, 1) == 1) wait_idle();
      end
      wait_idle();

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_l2_mem_responder
